// File: rtl/deserializador_serial_pkg.sv
// Shared serial-line definitions: FSM states and line levels.
// Also meant to be reused by the matching serializer.
package pacote_serial;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        DADOS  = 2'd1,
        PARADA = 2'd2
    } estado_t;

    localparam logic BIT_INICIO   = 1'b0;
    localparam logic BIT_PARADA   = 1'b1;
    localparam logic NIVEL_OCIOSO = 1'b1;

endpackage

// File: rtl/deserializador_serial_registrador.sv
// Right-shifting register: serial bit enters at the MSB, so an LSB-first
// stream ends up in natural bit order after LARGURA shifts.
module registrador_deslocamento #(
    parameter int LARGURA = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               habilita,
    input  logic               serial,
    output logic [LARGURA-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= '0;
        else if (habilita)
            q <= {serial, q[LARGURA-1:1]};
    end

endmodule

// File: rtl/deserializador_serial.sv
// Framed serial receiver: start bit 0, LARGURA data bits LSB-first, stop bit 1.
// The FSM, bit counter and registered outputs live here; data shifting is in registrador_deslocamento.
module deserializador_serial
    import pacote_serial::*;
#(
    parameter int LARGURA = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               entrada,
    input  logic               amostra,
    output logic [LARGURA-1:0] saida,
    output logic               saida_valida,
    output logic               erro_quadro,
    output logic               ocupado
);

    localparam int CW = $clog2(LARGURA + 1);
    localparam logic [CW-1:0] ULTIMO = CW'(LARGURA - 1);

    estado_t            estado;
    logic [CW-1:0]      contador;
    logic [LARGURA-1:0] deslocado;
    logic               desloca_en;

    assign desloca_en = amostra && (estado == DADOS);

    registrador_deslocamento #(
        .LARGURA(LARGURA)
    ) u_deslocamento (
        .clk     (clk),
        .reset   (reset),
        .habilita(desloca_en),
        .serial  (entrada),
        .q       (deslocado)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado       <= OCIOSO;
            contador     <= '0;
            saida        <= '0;
            saida_valida <= 1'b0;
            erro_quadro  <= 1'b0;
            ocupado      <= 1'b0;
        end else begin
            saida_valida <= 1'b0;
            erro_quadro  <= 1'b0;
            if (amostra) begin
                case (estado)
                    OCIOSO: begin
                        if (entrada == BIT_INICIO) begin
                            estado   <= DADOS;
                            contador <= '0;
                            ocupado  <= 1'b1;
                        end
                    end
                    DADOS: begin
                        contador <= contador + 1'b1;
                        if (contador == ULTIMO)
                            estado <= PARADA;
                    end
                    PARADA: begin
                        // The last data bit was shifted on the edge that entered PARADA.
                        estado  <= OCIOSO;
                        ocupado <= 1'b0;
                        if (entrada == BIT_PARADA) begin
                            saida        <= deslocado;
                            saida_valida <= 1'b1;
                        end else begin
                            erro_quadro <= 1'b1;
                        end
                    end
                    default: begin
                        estado  <= OCIOSO;
                        ocupado <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_deserializador_serial.sv
// Directed plus randomized frames checked against a word-level model of the receiver.
module tb_deserializador_serial;

    logic       clk = 1'b0;
    logic       reset;
    logic       entrada;
    logic       amostra;
    logic [7:0] saida;
    logic       saida_valida;
    logic       erro_quadro;
    logic       ocupado;

    int ncmp = 0;
    int nfail = 0;
    int nval = 0;
    int nerr = 0;
    int nocup = 0;
    int exp_nval = 0;
    int exp_nerr = 0;
    logic [7:0] exp_saida = 8'h00;

    deserializador_serial #(.LARGURA(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .entrada     (entrada),
        .amostra     (amostra),
        .saida       (saida),
        .saida_valida(saida_valida),
        .erro_quadro (erro_quadro),
        .ocupado     (ocupado)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (saida_valida) nval++;
        if (erro_quadro)  nerr++;
        if (ocupado)      nocup++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One strobe after per-1 idle cycles in which the line toggles freely.
    task automatic send_bit(input logic b, input int per);
        for (int k = 0; k < per - 1; k++) begin
            amostra = 1'b0;
            entrada = ~entrada;
            @(negedge clk);
        end
        amostra = 1'b1;
        entrada = b;
        @(negedge clk);
        amostra = 1'b0;
        entrada = 1'b1;
    endtask

    // Sends a full frame; on return the stop-bit result is visible on the outputs.
    task automatic send_frame(input string tag, input logic [7:0] w, input logic stopb, input int per);
        send_bit(1'b0, per);
        for (int i = 0; i < 8; i++) send_bit(w[i], per);
        send_bit(stopb, per);
        if (stopb) begin
            exp_saida = w;
            exp_nval++;
        end else begin
            exp_nerr++;
        end
        chk({tag, ".valida"}, 32'(saida_valida), 32'(stopb));
        chk({tag, ".erro"}, 32'(erro_quadro), 32'(!stopb));
        chk({tag, ".saida"}, 32'(saida), 32'(exp_saida));
        chk({tag, ".ocupado"}, 32'(ocupado), 32'd0);
    endtask

    initial begin
        int snap;
        reset = 1'b1;
        entrada = 1'b1;
        amostra = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.saida", 32'(saida), 32'h0);
        chk("rst.ocupado", 32'(ocupado), 32'h0);
        chk("rst.valida", 32'(saida_valida), 32'h0);
        reset = 1'b0;
        repeat (5) send_bit(1'b1, 1);
        @(negedge clk);
        chk("idle.ocupado", 32'(ocupado), 32'h0);
        chk("idle.saida", 32'(saida), 32'h0);
        chk("idle.pulses", 32'(nval + nerr), 32'h0);

        snap = nocup;
        send_frame("a5", 8'hA5, 1'b1, 1);
        chk("a5.ocupado_cycles", 32'(nocup - snap), 32'd9);
        @(negedge clk);
        chk("a5.pulse_one_cycle", 32'(saida_valida), 32'h0);

        send_frame("3c", 8'h3C, 1'b1, 4);
        send_frame("5a", 8'h5A, 1'b1, 2);
        send_frame("ff_bad", 8'hFF, 1'b0, 1);
        send_frame("b2b_01", 8'h01, 1'b1, 1);
        send_frame("b2b_80", 8'h80, 1'b1, 1);

        // Abort mid-frame after 4 data bits.
        send_bit(1'b0, 1);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom), 1);
        reset = 1'b1;
        #1;
        chk("abort.ocupado", 32'(ocupado), 32'h0);
        chk("abort.saida", 32'(saida), 32'h0);
        exp_saida = 8'h00;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        send_frame("c3", 8'hC3, 1'b1, 1);

        // Reset coincident with the stop sample wins.
        send_bit(1'b0, 1);
        for (int i = 0; i < 8; i++) send_bit(1'($urandom), 1);
        amostra = 1'b1;
        entrada = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        amostra = 1'b0;
        chk("rst_stop.valida", 32'(saida_valida), 32'h0);
        chk("rst_stop.saida", 32'(saida), 32'h0);
        exp_saida = 8'h00;
        reset = 1'b0;
        @(negedge clk);

        for (int f = 0; f < 24; f++) begin
            int idle = $urandom_range(0, 2);
            for (int k = 0; k < idle; k++) send_bit(1'b1, $urandom_range(1, 3));
            send_frame("rnd", 8'($urandom), ($urandom_range(0, 4) != 0), $urandom_range(1, 4));
        end

        repeat (3) @(negedge clk);
        chk("total.valida", 32'(nval), 32'(exp_nval));
        chk("total.erro", 32'(nerr), 32'(exp_nerr));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
